// File: rtl/gcd_pkg.sv
// Shared types and select encodings for the GCD controller slice.
// Latency/backpressure: none, declarations only.
// Optional timeout feature is controlled by GCD_TIMEOUT_EN.
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic SEL_A   = 1'b1;
  localparam logic SEL_B   = 1'b0;
  localparam logic BUS_DIN = 1'b0;
  localparam logic BUS_SUB = 1'b1;

endpackage

// File: rtl/gcd_ctrl_fsm_if.sv
// Control/handshake bundle between the GCD controller, its datapath and the system.
// Latency: wires only; backpressure is carried by op_valid/op_ready and res_ack.
// Optional timeout feature (err) is controlled by GCD_TIMEOUT_EN.
interface gcd_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             op_valid;
  logic             op_ready;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             res_ack;
  logic             sel1;
  logic             sel2;
  logic             sel_in;
  logic             ldA;
  logic             ldB;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;

  // System plus datapath side.
  modport master (
    output start, op_valid, lt, gt, eq, res_ack,
    input  op_ready, sel1, sel2, sel_in, ldA, ldB, busy, done, err, iter_cnt
  );

  // Controller side.
  modport slave (
    input  start, op_valid, lt, gt, eq, res_ack,
    output op_ready, sel1, sel2, sel_in, ldA, ldB, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/gcd_iter_counter.sv
// Saturating subtract counter with clear; limit compare present only with GCD_TIMEOUT_EN.
// Latency: count visible the cycle after inc; clear has priority over inc.
// Backpressure: none, the controller decides when to increment.
module gcd_iter_counter #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
`ifdef GCD_TIMEOUT_EN
  output logic             limit_hit,
`endif
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef GCD_TIMEOUT_EN
  assign limit_hit = (cnt == CNT_W'(MAX_ITER));
`else
  localparam int max_iter_unused = MAX_ITER;
`endif

endmodule

// File: rtl/gcd_ctrl_fsm.sv
// Control FSM for the subtractive GCD datapath: load A, load B, subtract until eq, hold done until res_ack.
// Latency: 2 load cycles (min) + N subtracts + 1 eq-detect cycle to done.
// Backpressure: waits on op_valid in load states and on res_ack in S_DONE; GCD_TIMEOUT_EN adds an iteration limit.
module gcd_ctrl_fsm
  import gcd_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  gcd_ctrl_fsm_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             err_set;
  logic             limit_hit;
  logic [CNT_W-1:0] cnt;

  gcd_iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
`ifdef GCD_TIMEOUT_EN
    .limit_hit (limit_hit),
`endif
    .cnt       (cnt)
  );

`ifndef GCD_TIMEOUT_EN
  assign limit_hit = 1'b0;
`endif

  assign bus.iter_cnt = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Mealy outputs: loads follow op_valid / flags in the same cycle.
  always_comb begin
    state_nxt    = state;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    err_set      = 1'b0;
    bus.op_ready = 1'b0;
    bus.sel1     = SEL_B;
    bus.sel2     = SEL_B;
    bus.sel_in   = BUS_DIN;
    bus.ldA      = 1'b0;
    bus.ldB      = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_LOAD_A;
          cnt_clr   = 1'b1;
        end
      end
      S_LOAD_A: begin
        bus.busy     = 1'b1;
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          bus.ldA   = 1'b1;
          state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        bus.busy     = 1'b1;
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          bus.ldB   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        bus.busy   = 1'b1;
        bus.sel_in = BUS_SUB;
        if (bus.eq) begin
          state_nxt = S_DONE;
        end else if (limit_hit) begin
          state_nxt = S_DONE;
          err_set   = 1'b1;
        end else if (bus.gt) begin
          bus.sel1 = SEL_A;
          bus.sel2 = SEL_B;
          bus.ldA  = 1'b1;
          cnt_inc  = 1'b1;
        end else if (bus.lt) begin
          bus.sel1 = SEL_B;
          bus.sel2 = SEL_A;
          bus.ldB  = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.res_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A reset cycle must never load the datapath or signal the system.
    if (!rst_n) begin
      state_nxt    = S_IDLE;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      err_set      = 1'b0;
      bus.op_ready = 1'b0;
      bus.sel1     = 1'b0;
      bus.sel2     = 1'b0;
      bus.sel_in   = 1'b0;
      bus.ldA      = 1'b0;
      bus.ldB      = 1'b0;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
    end
  end

`ifdef GCD_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (cnt_clr) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
  logic err_set_unused;
  assign err_set_unused = err_set;
`endif

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Bench: behavioural GCD datapath around gcd_ctrl_fsm, directed runs, done-triggered scoreboard.
module tb_gcd_ctrl_fsm;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [15:0]      res;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [15:0] data_in;
  logic [15:0] dp_a;
  logic [15:0] dp_b;
  logic [15:0] sub_out;
  logic [15:0] bus_val;

  int checks;
  int errors;
  int both_ld_hits;
  exp_t exp_q[$];
  logic done_q;

  gcd_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  gcd_ctrl_fsm #(
    .CNT_W    (CNT_W),
    .MAX_ITER (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  assign sub_out = (bus.sel1 ? dp_a : dp_b) - (bus.sel2 ? dp_a : dp_b);
  assign bus_val = bus.sel_in ? sub_out : data_in;
  assign bus.lt  = dp_a < dp_b;
  assign bus.gt  = dp_a > dp_b;
  assign bus.eq  = dp_a == dp_b;

  always_ff @(posedge clk) begin
    if (bus.ldA) dp_a <= bus_val;
    if (bus.ldB) dp_b <= bus_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare result on each rising edge of done.
  always @(negedge clk) begin
    if (rst_n && bus.done && !done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0d with no expected entry", dp_a);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(dp_a), 32'(e.res));
        check("iter_cnt", 32'(bus.iter_cnt), 32'(e.cnt));
        check("err", 32'(bus.err), 32'(e.err));
      end
    end
    if (bus.ldA && bus.ldB) begin
      both_ld_hits++;
    end
    assert (!(bus.ldA && bus.ldB)) else $display("FAIL ld_both: ldA and ldB high together");
    done_q = bus.done;
  end

  task automatic load(input logic [15:0] a, input logic [15:0] b, input int gap);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.op_valid = 1'b1;
    data_in      = a;
    @(posedge clk); #1;
    if (gap > 0) begin
      bus.op_valid = 1'b0;
      data_in      = 16'hdead;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        check("stall_op_ready", 32'(bus.op_ready), 32'd1);
        check("stall_ldB", 32'(bus.ldB), 32'd0);
        @(posedge clk); #1;
      end
      bus.op_valid = 1'b1;
    end
    data_in = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic finish_run(input bit pulse);
    bit seen;
    if (pulse) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not seen within 300 cycles, required 1");
    end
    if (pulse) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(negedge clk);
      check("start_in_done_ignored", 32'(bus.done), 32'd1);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    @(posedge clk); #1;
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    check("done_after_ack", 32'(bus.done), 32'd0);
    check("busy_after_ack", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    both_ld_hits = 0;
    done_q       = 1'b0;
    rst_n        = 1'b0;
    data_in      = '0;
    bus.start    = 1'b0;
    bus.op_valid = 1'b0;
    bus.res_ack  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check("rst_ldA", 32'(bus.ldA), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_iter_cnt", 32'(bus.iter_cnt), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    // (48,18): 4 subtracts -> 6
    exp_q.push_back('{res: 16'd6, cnt: 16'd4, err: 1'b0});
    load(16'd48, 16'd18, 0);
    finish_run(1'b0);

    // (7,7): equal at once
    exp_q.push_back('{res: 16'd7, cnt: 16'd0, err: 1'b0});
    load(16'd7, 16'd7, 0);
    finish_run(1'b0);

    // (0,0): equal at once, result 0
    exp_q.push_back('{res: 16'd0, cnt: 16'd0, err: 1'b0});
    load(16'd0, 16'd0, 0);
    finish_run(1'b0);

    // B load stalled 3 cycles
    exp_q.push_back('{res: 16'd6, cnt: 16'd4, err: 1'b0});
    load(16'd48, 16'd18, 3);
    finish_run(1'b0);

    // start pulsed in S_RUN and S_DONE
    exp_q.push_back('{res: 16'd6, cnt: 16'd4, err: 1'b0});
    load(16'd48, 16'd18, 0);
    finish_run(1'b1);

    // (9,21): (9,12)(9,3)(6,3)(3,3) -> 3
    exp_q.push_back('{res: 16'd3, cnt: 16'd4, err: 1'b0});
    load(16'd9, 16'd21, 0);
    finish_run(1'b0);

    // One operand zero
`ifdef GCD_TIMEOUT_EN
    exp_q.push_back('{res: 16'd13, cnt: 16'd16, err: 1'b1});
    load(16'd13, 16'd0, 0);
    finish_run(1'b0);
    check("err_held_idle", 32'(bus.err), 32'd1);
`else
    begin
      bit stayed;
      load(16'd13, 16'd0, 0);
      stayed = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (!bus.busy || bus.done) stayed = 1'b0;
      end
      check("busy_stuck_100", 32'(stayed), 32'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
    end
`endif

    // Reset for one cycle in S_RUN of (48,18): A=30 after first subtract
    load(16'd48, 16'd18, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_run_ldA", 32'(bus.ldA), 32'd0);
    check("rst_run_ldB", 32'(bus.ldB), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_run_a_held", 32'(dp_a), 32'd30);
    check("rst_run_busy", 32'(bus.busy), 32'd0);
    check("rst_run_done", 32'(bus.done), 32'd0);
    check("rst_run_iter_cnt", 32'(bus.iter_cnt), 32'd0);
    check("rst_run_err", 32'(bus.err), 32'd0);

    exp_q.push_back('{res: 16'd6, cnt: 16'd4, err: 1'b0});
    load(16'd48, 16'd18, 0);
    finish_run(1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("ld_both_never", 32'(both_ld_hits), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
